// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Optional `DIV_SPECIAL_BYPASS_EN: divide-by-zero and signed overflow resolve in one cycle.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        is_signed,
    input  logic        is_rem,
    input  logic        word_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] res
);

`ifdef DIV_SPECIAL_BYPASS_EN
    localparam bit bypass_en = 1'b1;
`else
    localparam bit bypass_en = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [6:0]  cnt;
    logic        accept;

    // Latched operation context
    logic [63:0] dvd;
    logic [63:0] dsr;
    logic [63:0] quo;
    logic [63:0] rem;
    logic [63:0] spec_res;
    logic        neg_q, neg_r, rem_op, word_r, special_r;

    // Accept-time operand preparation
    logic [63:0] a_ext, b_ext, a_mag, b_mag;
    logic        a_neg, b_neg, div_zero, overflow, special;
    logic [63:0] spec_raw, spec_val;

    // Iteration step and final fixup
    logic [64:0] trial, diff;
    logic        q_bit;
    logic [63:0] rem_nxt, quo_nxt, q_fix, r_fix, sel, fin;

    function automatic logic [63:0] sext32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready && !flush;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        a_ext = a;
        b_ext = b;
        if (word_op) begin
            a_ext = is_signed ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]};
            b_ext = is_signed ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]};
        end
        a_neg    = is_signed && a_ext[63];
        b_neg    = is_signed && b_ext[63];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        overflow = is_signed && (b_ext == '1) &&
                   (a_ext == (word_op ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        special  = div_zero || overflow;
        if (div_zero)
            spec_raw = is_rem ? a_ext : '1;
        else
            spec_raw = is_rem ? '0 : a_ext;
        spec_val = word_op ? sext32(spec_raw) : spec_raw;
    end

    // A borrow out of the 65-bit trial means the divisor did not fit.
    always_comb begin
        trial   = {rem, dvd[63]};
        diff    = trial - {1'b0, dsr};
        q_bit   = !diff[64];
        rem_nxt = q_bit ? diff[63:0] : trial[63:0];
        quo_nxt = {quo[62:0], q_bit};
        q_fix   = neg_q ? -quo_nxt : quo_nxt;
        r_fix   = neg_r ? -rem_nxt : rem_nxt;
        sel     = rem_op ? r_fix : q_fix;
        fin     = special_r ? spec_res : (word_r ? sext32(sel) : sel);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (special && bypass_en) ? DONE : BUSY;
            BUSY: if (cnt == 7'd1) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            res   <= '0;
        end else begin
            state <= state_nxt;
            if (flush)
                cnt <= '0;
            else if (accept)
                cnt <= word_op ? 7'd32 : 7'd64;
            else if (state == BUSY)
                cnt <= cnt - 7'd1;

            if (accept && special && bypass_en)
                res <= spec_val;
            else if (!flush && state == BUSY && cnt == 7'd1)
                res <= fin;
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd       <= word_op ? {a_mag[31:0], 32'h0} : a_mag;
            dsr       <= b_mag;
            quo       <= '0;
            rem       <= '0;
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
            rem_op    <= is_rem;
            word_r    <= word_op;
            special_r <= special;
            spec_res  <= spec_val;
        end else if (state == BUSY) begin
            dvd <= {dvd[62:0], 1'b0};
            quo <= quo_nxt;
            rem <= rem_nxt;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: arithmetic, special cases, latency,
// backpressure, flush and mid-operation reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [63:0] a, b, res;
    logic        is_signed, is_rem, word_op, out_valid, out_ready;

    int vectors    = 0;
    int miscompares = 0;

`ifdef DIV_SPECIAL_BYPASS_EN
    localparam int spec_lat64 = 0;
    localparam int spec_lat32 = 0;
`else
    localparam int spec_lat64 = 64;
    localparam int spec_lat32 = 32;
`endif

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .is_rem    (is_rem),
        .word_op   (word_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [63:0] op_a, input logic [63:0] op_b,
                             input bit s, input bit r, input bit w);
        a         = op_a;
        b         = op_b;
        is_signed = s;
        is_rem    = r;
        word_op   = w;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [63:0] op_a, input logic [63:0] op_b,
                          input bit s, input bit r, input bit w,
                          input logic [63:0] exp_res, input int exp_lat);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check({tag, " ready"}, 64'(in_ready), 64'd1);
        drive_req(op_a, op_b, s, r, w);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " res"}, res, exp_res);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        is_rem    = 1'b0;
        word_op   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset res", res, 64'd0);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);

        run_op("divu 100/7",   64'd100, 64'd7, 0, 0, 0, 64'd14, 64);
        run_op("remu 100/7",   64'd100, 64'd7, 0, 1, 0, 64'd2, 64);
        run_op("div -7/2",     64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64);
        run_op("rem -7/2",     64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        run_op("divw ovf",     64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 0, 1,
               64'hFFFF_FFFF_8000_0000, spec_lat32);
        run_op("remw ovf",     64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 1, 1,
               64'd0, spec_lat32);
        run_op("divu by 0",    64'h1234, 64'd0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, spec_lat64);
        run_op("remu by 0",    64'h1234, 64'd0, 0, 1, 0, 64'h1234, spec_lat64);
        run_op("rem -5 by 0",  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFB, spec_lat64);
        run_op("div ovf 64",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0,
               64'h8000_0000_0000_0000, spec_lat64);
        run_op("divuw max/1",  64'h0000_0000_FFFF_FFFF, 64'd1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 32);
        run_op("divuw 17/5",   64'hDEAD_0000_0000_0011, 64'hBEEF_0000_0000_0005, 0, 0, 1, 64'd3, 32);
        run_op("remuw 17/5",   64'hDEAD_0000_0000_0011, 64'hBEEF_0000_0000_0005, 0, 1, 1, 64'd2, 32);
        run_op("divw -7/3",    64'h0000_0000_FFFF_FFF9, 64'd3, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 32);
        run_op("remw -7/3",    64'h0000_0000_FFFF_FFF9, 64'd3, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 32);

        // Backpressure: result held in DONE, other requests refused.
        out_ready = 1'b0;
        drive_req(64'd1000, 64'd10, 0, 0, 0);
        seen = 0;
        while (!out_valid && seen < 200) begin
            @(posedge clk);
            #1;
            seen++;
        end
        check("bp first valid", 64'(out_valid), 64'd1);
        check("bp res", res, 64'd100);
        a        = 64'd55;
        b        = 64'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp hold res", res, 64'd100);
            check("bp hold in_ready", 64'(in_ready), 64'd0);
            check("bp hold out_valid", 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release out_valid", 64'(out_valid), 64'd0);
        check("bp release in_ready", 64'(in_ready), 64'd1);

        // Flush during BUSY cycle 20.
        drive_req(64'd100, 64'd7, 0, 0, 0);
        repeat (19) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush in_ready", 64'(in_ready), 64'd1);
        check("flush out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("flush no result", 64'(seen), 64'd0);
        check("flush res kept", res, 64'd100);

        // Flush and request in the same IDLE cycle: no accept.
        a        = 64'd9;
        b        = 64'd3;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush+valid not accepted", 64'(in_ready), 64'd1);

        // Reset in the middle of BUSY.
        drive_req(64'd100, 64'd7, 0, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst res", res, 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd1);
        run_op("divu 100/10", 64'd100, 64'd10, 0, 0, 0, 64'd10, 64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV64M divide/remainder unit beside `exu` in the EX stage. It takes operands through a valid/ready request port and returns one 64-bit result through a valid/ready response port. The pipeline stalls in EX while the unit is busy. It handles DIV, DIVU, REM, REMU and the word forms (DIVW, DIVUW, REMW, REMUW) using a radix-2 restoring algorithm that produces one quotient bit per cycle.

## Interface
- No parameters; data width fixed at 64 (`` `width `` = [63:0]).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: pipeline flush; aborts any operation.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit can accept a request.
- `a` input 64: dividend.
- `b` input 64: divisor.
- `is_signed` input 1: signed operation (DIV/REM family).
- `is_rem` input 1: 1 returns the remainder, 0 returns the quotient.
- `word_op` input 1: 32-bit (W) operation.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `res` output 64: result.

## Operation
- States are IDLE, BUSY and DONE.
- `in_ready` = (state == IDLE) && !rst.
- **Accept:** `in_valid && in_ready && !flush`. On accept the unit latches the operation flags, the operand magnitudes, the quotient and remainder sign flags, and the iteration count N.
  - N = 32 if `word_op`, else 64.
- **Word ops:** the operands are the low 32 bits of `a` and `b`.
  - Signed: sign-extended to 64 bits.
  - Unsigned: zero-extended to 64 bits.
  - The final 32-bit result is always sign-extended from bit 31 into `res`.
- **Signed ops:** the unit divides magnitudes.
  - The quotient is negated if the signs of `a` and `b` differ.
  - The remainder takes the sign of the dividend.
- **BUSY:** each cycle, shift the partial remainder left by one and bring in the next dividend bit (MSB first). Trial-subtract the divisor. If no borrow, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0. Decrement the counter.
  - When the counter reaches 0, apply sign fixup, register `res`, and go to DONE.
- **Special cases** (width = 32 or 64 per `word_op`):
  - Divisor zero: quotient = all ones (0xFFFF_FFFF_FFFF_FFFF; the W form also yields that after sign-extension). Remainder = dividend, sign-extended for W.
  - Signed overflow (dividend = most-negative, divisor = −1): quotient = dividend; remainder = 0.
- **DONE:** `out_valid` = 1 and `res` is held stable.
  - On `out_valid && out_ready`, return to IDLE.
  - No new request is accepted in DONE.
- **Flush:** from any state, go to IDLE on the next edge. `out_valid` drops, and no result is delivered for the aborted operation.
  - If `flush` and `in_valid` are high in the same IDLE cycle, the request is not accepted.
- **Reset:** state = IDLE, `out_valid` = 0, `res` = 0, counter = 0. Reset asserted mid-operation discards the operation.

## Timing
- Accept at edge t. Normal ops assert `out_valid` from cycle t+N+1: t+65 for 64-bit ops, t+33 for W ops.
- Special cases (with `DIV_SPECIAL_BYPASS_EN`) go IDLE→DONE directly, so `out_valid` is asserted from cycle t+1.
- `out_valid` is registered, not combinational from inputs. `res` changes only on the edge entering DONE.
- `in_ready` is high from the cycle after the DONE handshake or after a flush. Minimum request spacing is N+2 cycles.
- `out_ready` may be held low indefinitely. The unit stays in DONE with `res` unchanged.
- `flush` has priority over `out_ready`, `in_valid`, and the iteration step.

## Configuration
- `DIV_SPECIAL_BYPASS_EN`
  - **Defined:** divisor-zero and signed-overflow cases are detected at accept and resolved in one cycle, going IDLE→DONE.
  - **Undefined:** these cases are still detected at accept and produce identical `res` values, but pass through BUSY for the full N cycles, giving a uniform latency.
- Results never differ between the two builds; only latency does.

## Test plan
- DIVU, 64-bit: a=100, b=7, out_ready=1. Expect `res`=14 with `out_valid` at t+65. With `is_rem`=1, expect `res`=2.
- DIV signed: a=−7, b=2. Expect quotient −3 (0xFFFF_FFFF_FFFF_FFFD). With `is_rem`=1, expect remainder −1 (0xFFFF_FFFF_FFFF_FFFF).
- DIVW: a=0x0000_0001_8000_0000, b=0xFFFF_FFFF (−1 as 32-bit). Expect overflow quotient 0xFFFF_FFFF_8000_0000; REMW gives 0.
  - Bypass build: `out_valid` at t+1. Non-bypass build: t+33.
- DIVU by zero: a=0x1234, b=0. Expect quotient 0xFFFF_FFFF_FFFF_FFFF; REMU returns 0x1234.
- Backpressure and flush:
  - Hold `out_ready`=0 for 10 cycles after `out_valid`. `res` must stay stable and `in_ready` must stay 0.
  - Separately, assert `flush` at BUSY cycle 20. Expect `out_valid` never rises and `in_ready`=1 on the next cycle.
- Reset mid-BUSY: assert `rst` for one cycle. Expect `out_valid`=0 and `res`=0; after deassert, a new request (100/10) returns 10.
